fp_round_pipe: RTL and testbench

Two-stage, valid/ready-handshaked rounding stage that sits directly downstream of the FMA and other arithmetic cores. It consumes an unrounded result bundle (`uround_res_t`) plus a rounding mode and produces the IEEE-754 rounded result and accumulated exception flags. Backpressure is supported with no loss or duplication of results.

---
 rtl/fp_round_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp_round_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pipe.sv
// Two-stage valid/ready rounding stage. S1 latches the unrounded bundle and decides the
// round-up bit; S2 applies it, substitutes overflow/NaN results and registers the output.

package fp_pkg;
   typedef enum logic [1:0] {FP32 = 2'd0, FP16 = 2'd1, BF16 = 2'd2} fp_format_e;
   typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

   // The bundle is sized for the widest supported format; narrower formats use the low bits.
   localparam int UR_WIDTH = 32;

   typedef struct packed {
      logic [UR_WIDTH-1:0] u_result;
      logic [1:0]          rs;
      logic                round_en;
      logic                invalid;
      logic [1:0]          exp_cout;
   } uround_res_t;

   function automatic int exp_width(fp_format_e f);
      case (f)
         FP16:    return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int mant_width(fp_format_e f);
      case (f)
         FP16:    return 10;
         BF16:    return 7;
         default: return 23;
      endcase
   endfunction

   function automatic int fp_width(fp_format_e f);
      return 1 + exp_width(f) + mant_width(f);
   endfunction
endpackage

module fp_round_pipe
   import fp_pkg::*;
#(
   parameter  fp_format_e FP_FORMAT  = FP32,
   localparam int         EXP_WIDTH  = exp_width(FP_FORMAT),
   localparam int         MANT_WIDTH = mant_width(FP_FORMAT),
   localparam int         FP_WIDTH   = fp_width(FP_FORMAT)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  uround_res_t         urnd_i,
   input  roundmode_e          rnd_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [FP_WIDTH-1:0] result_o,
   output logic [4:0]          fflags_o
);

   localparam int EMW = EXP_WIDTH + MANT_WIDTH;

   // ---------------- pipeline control ----------------
   logic s1_valid, s2_valid;
   logic s1_adv, s2_adv;

   assign s2_adv     = ~s2_valid | out_ready_i;
   assign s1_adv     = ~s1_valid | s2_adv;
   assign in_ready_o = s1_adv;

   // ---------------- S1: decide ----------------
   logic           in_sign;
   logic [EMW-1:0] in_em;
   logic           in_l, in_r, in_s;
   logic           in_rup;
   logic           in_rnx;

   assign in_sign = urnd_i.u_result[FP_WIDTH-1];
   assign in_em   = urnd_i.u_result[EMW-1:0];
   assign in_l    = in_em[0];
   assign in_r    = urnd_i.rs[1];
   assign in_s    = urnd_i.rs[0];
   assign in_rnx  = urnd_i.round_en & (in_r | in_s);

   always_comb begin
      in_rup = 1'b0;
      if (urnd_i.round_en) begin
         case (rnd_i)
            RNE:     in_rup = in_r & (in_s | in_l);
            RTZ:     in_rup = 1'b0;
            RDN:     in_rup = in_sign & (in_r | in_s);
            RUP:     in_rup = ~in_sign & (in_r | in_s);
            RMM:     in_rup = in_r;
            default: in_rup = 1'b0;
         endcase
      end
   end

   logic           s1_sign, s1_rup, s1_rnx, s1_ren, s1_inv, s1_ovf, s1_unf;
   logic [EMW-1:0] s1_em;
   roundmode_e     s1_mode;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_em    <= '0;
         s1_rup   <= 1'b0;
         s1_rnx   <= 1'b0;
         s1_ren   <= 1'b0;
         s1_inv   <= 1'b0;
         s1_ovf   <= 1'b0;
         s1_unf   <= 1'b0;
         s1_mode  <= RNE;
      end else if (s1_adv) begin
         s1_valid <= in_valid_i;
         if (in_valid_i) begin
            s1_sign <= in_sign;
            s1_em   <= in_em;
            s1_rup  <= in_rup;
            s1_rnx  <= in_rnx;
            s1_ren  <= urnd_i.round_en;
            s1_inv  <= urnd_i.invalid;
            s1_ovf  <= urnd_i.exp_cout[1];
            s1_unf  <= urnd_i.exp_cout[0];
            s1_mode <= rnd_i;
         end
      end
   end

   // ---------------- S2: apply ----------------
   // One combined add lets a mantissa carry ripple straight into the exponent.
   logic [EMW-1:0]       sum;
   logic [EXP_WIDTH-1:0] post_exp;
   logic                 of, nx, uf;
   logic [FP_WIDTH-1:0]  inf_res, max_res, of_res, qnan_res;
   logic [FP_WIDTH-1:0]  s2_result_next;
   logic [4:0]           s2_flags_next;

   assign sum      = s1_em + {{(EMW-1){1'b0}}, s1_rup};
   assign post_exp = sum[EMW-1:MANT_WIDTH];
   // Bypassed bundles take overflow from exp_cout alone.
   assign of       = s1_ovf | (s1_ren & (&post_exp));
   assign nx       = s1_rnx | of;
   assign uf       = s1_unf & nx;

   assign inf_res  = {s1_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
   assign max_res  = {s1_sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
   assign qnan_res = {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

   always_comb begin
      of_res = inf_res;
      case (s1_mode)
         RNE, RMM: of_res = inf_res;
         RTZ:      of_res = max_res;
         RDN:      of_res = s1_sign ? inf_res : max_res;
         RUP:      of_res = s1_sign ? max_res : inf_res;
         default:  of_res = inf_res;
      endcase
   end

   always_comb begin
      s2_result_next = {s1_sign, sum};
      s2_flags_next  = {3'b000, uf, nx};
      if (s1_inv) begin
         s2_result_next = qnan_res;
         s2_flags_next  = 5'b10000;
      end else if (of) begin
         s2_result_next = of_res;
         s2_flags_next  = {2'b00, 1'b1, uf, nx};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid <= 1'b0;
         result_o <= '0;
         fflags_o <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result_o <= s2_result_next;
            fflags_o <= s2_flags_next;
         end
      end
   end

   assign out_valid_o = s2_valid;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: a driver pushes hand-computed expectations,
// an independent monitor pops and compares each output transfer.
module tb_fp_round_pipe;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   uround_res_t urnd = '0;
   roundmode_e  rnd = RNE;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [4:0]  fflags;

   fp_round_pipe #(.FP_FORMAT(FP32)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .urnd_i     (urnd),
      .rnd_i      (rnd),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .result_o   (result),
      .fflags_o   (fflags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  ff;
      int          acc_cyc;
      bit          chk_lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: samples mid-low-phase, well clear of the rising edge.
   initial begin
      logic [31:0] held_res;
      logic [4:0]  held_ff;
      bit          held;
      exp_t        e;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            held = 1'b0;
            continue;
         end
         if (held && out_valid) begin
            n_cmp++;
            if (result !== held_res || fflags !== held_ff) begin
               n_bad++;
               $display("FAIL stall_hold: got %h/%b, required %h/%b", result, fflags, held_res, held_ff);
            end
         end
         held = 1'b0;
         if (out_valid && !out_ready) begin
            held     = 1'b1;
            held_res = result;
            held_ff  = fflags;
         end else if (out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_output: got %h/%b, required no output", result, fflags);
            end else begin
               e = sb.pop_front();
               if (result !== e.res || fflags !== e.ff) begin
                  n_bad++;
                  $display("FAIL %s: got %h/%b, required %h/%b", e.name, result, fflags, e.res, e.ff);
               end else begin
                  $display("txn %s: result=%h fflags=%b", e.name, result, fflags);
               end
               if (e.chk_lat) begin
                  n_cmp++;
                  if (cyc - e.acc_cyc != 2) begin
                     n_bad++;
                     $display("FAIL %s_latency: got %0d, required 2", e.name, cyc - e.acc_cyc);
                  end
               end
            end
         end
      end
   end

   task automatic send(input string name, input logic [31:0] u, input logic [1:0] rs,
                       input logic ren, input logic inv, input logic [1:0] ec,
                       input roundmode_e m, input logic [31:0] xres, input logic [4:0] xff,
                       input bit lat);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      urnd     = '{u_result: u, rs: rs, round_en: ren, invalid: inv, exp_cout: ec};
      rnd      = m;
      forever begin
         #2;
         if (in_ready) begin
            e.res = xres; e.ff = xff; e.acc_cyc = cyc; e.chk_lat = lat; e.name = name;
            sb.push_back(e);
            break;
         end
         guard++;
         if (guard > 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept_timeout: got in_ready=0, required 1", name);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   initial begin
      bit saw_full;

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_fflags", {27'b0, fflags}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check("ready_after_reset", {31'b0, in_ready}, 32'd1);

      // RNE back-to-back with carry into exponent
      send("rne_up",    32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800001, 5'b00001, 1'b1);
      send("rne_tie",   32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001, 1'b1);
      send("rne_carry", 32'h3F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001, 1'b1);
      idle();
      wait_empty();

      // Overflow by mode, directed rounding/underflow, invalid, bypass
      send("ovf_rne",  32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, RNE, 32'h7F800000, 5'b00101, 1'b0);
      send("ovf_rtz",  32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, RTZ, 32'h7F7FFFFF, 5'b00101, 1'b0);
      send("ovf_rdn_neg", 32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, RDN, 32'hFF800000, 5'b00101, 1'b0);
      send("ovf_rup_neg", 32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, RUP, 32'hFF7FFFFF, 5'b00101, 1'b0);
      send("unf_rup",  32'h00000001, 2'b01, 1'b1, 1'b0, 2'b01, RUP, 32'h00000002, 5'b00011, 1'b0);
      send("unf_rdn",  32'h00000001, 2'b01, 1'b1, 1'b0, 2'b01, RDN, 32'h00000001, 5'b00011, 1'b0);
      send("rmm_tie",  32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, RMM, 32'h3F800001, 5'b00001, 1'b0);
      send("invalid",  32'h12345678, 2'b11, 1'b1, 1'b1, 2'b10, RUP, 32'hFFC00000, 5'b10000, 1'b0);
      send("bypass",   32'h40490FDB, 2'b11, 1'b0, 1'b0, 2'b00, RNE, 32'h40490FDB, 5'b00000, 1'b0);
      idle();
      wait_empty();

      // Backpressure: 6 bundles with a 3-cycle downstream stall
      saw_full = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send($sformatf("bp%0d", i), 32'h40000000 + 32'(16 * i), 2'b11, 1'b1, 1'b0, 2'b00,
                    RNE, 32'h40000001 + 32'(16 * i), 5'b00001, 1'b0);
            end
            idle();
         end
         begin
            repeat (2) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
         begin
            repeat (12) begin
               @(negedge clk);
               #2;
               if (in_valid && !in_ready) saw_full = 1'b1;
            end
         end
      join
      check("bp_in_ready_drop", {31'b0, saw_full}, 32'd1);
      wait_empty();

      // Reset mid-stall with both stages full
      @(negedge clk);
      out_ready = 1'b0;
      send("stale_a", 32'h11111110, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h11111111, 5'b00001, 1'b0);
      send("stale_b", 32'h22222220, 2'b11, 1'b1, 1'b0, 2'b00, RNE, 32'h22222221, 5'b00001, 1'b0);
      idle();
      #2;
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("full_out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_fflags", {27'b0, fflags}, 32'd0);
      check("async_rst_result", result, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #2;
      check("ready_after_mid_reset", {31'b0, in_ready}, 32'd1);
      send("post_rst", 32'h3F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, RNE, 32'h3F800000, 5'b00001, 1'b1);
      idle();
      wait_empty();

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
